// File: rtl/drv_led_pkg.sv
// Shared types and constants for the LED pin driver and its sibling drivers.
package drv_led_pkg;

  // Driver FSM states; S_FLASH overrides all others until its timer expires.
  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_ON        = 3'd1,
    S_BLINK_ON  = 3'd2,
    S_BLINK_OFF = 3'd3,
    S_FLASH     = 3'd4
  } state_t;

  // Logical mode commands on i_mode; 2'b11 is reserved and behaves as off.
  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_ON    = 2'b01;
  localparam logic [1:0] LED_BLINK = 2'b10;

  // Pin polarity, shared with the switch input driver.
  localparam bit ACTIVE_LOW  = 1'b0;
  localparam bit ACTIVE_HIGH = 1'b1;

  // Larger of two lengths, used to size the phase tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/drv_led_tick.sv
// Free-running prescaler: one-clock tick every 2^p_scale clocks.
// A synchronous clear restarts the period so callers get exact phases.
module drv_led_tick #(
  parameter int p_scale = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [p_scale-1:0] cnt;

  // Count up every clock; reset or clear restart the period from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + p_scale'(1);
    end
  end

  // Tick on the last count of the period, just before the wrap.
  assign tick = &cnt;

endmodule

// File: rtl/drv_led.sv
// LED pin driver: turns off/on/blink commands plus a one-shot flash
// request into a polarity-correct, PWM-dimmed, registered pin level.
// i_flash is a level-sampled request with no acknowledge: every clock it
// is high (re)starts a full flash; o_busy is high while a flash runs.
// o_state exposes the FSM state for observation.
module drv_led
  import drv_led_pkg::*;
#(
  parameter int p_scale     = 5,
  parameter bit p_mode      = ACTIVE_LOW,
  parameter int p_pwm_bits  = 4,
  parameter int p_blink_len = 8,
  parameter int p_flash_len = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mode,
  input  logic [p_pwm_bits-1:0] i_level,
  input  logic                  i_flash,
  output logic                  o_busy,
  output logic                  o_drv_led,
  output state_t                o_state
);

  localparam int TW = $clog2(max_int(p_blink_len, p_flash_len) + 1);

  state_t                state;
  state_t                state_nxt;
  logic [TW-1:0]         tick_cnt;
  logic [p_pwm_bits-1:0] pwm_cnt;
  logic                  tick;
  logic                  clr;
  logic                  pwm_on;
  logic                  lit_nxt;
  logic                  blink_end;
  logic                  flash_end;

  drv_led_tick #(
    .p_scale(p_scale)
  ) u_tick (
    .clk (i_clk),
    .rst (i_rst),
    .clr (clr),
    .tick(tick)
  );

  // All-ones level means 100 % duty, otherwise compare against the ramp.
  assign pwm_on    = (&i_level) | (pwm_cnt < i_level);
  assign blink_end = tick && (tick_cnt == TW'(p_blink_len - 1));
  assign flash_end = tick && (tick_cnt == TW'(p_flash_len - 1));

  // Next state: flash beats mode; mode is ignored until a flash expires.
  always_comb begin
    state_nxt = state;
    if (i_flash) begin
      state_nxt = S_FLASH;
    end else if (state == S_FLASH) begin
      if (flash_end) begin
        case (i_mode)
          LED_ON:    state_nxt = S_ON;
          LED_BLINK: state_nxt = S_BLINK_ON;
          default:   state_nxt = S_OFF;
        endcase
      end
    end else begin
      case (i_mode)
        LED_ON: state_nxt = S_ON;
        LED_BLINK: begin
          case (state)
            S_BLINK_ON:  state_nxt = blink_end ? S_BLINK_OFF : S_BLINK_ON;
            S_BLINK_OFF: state_nxt = blink_end ? S_BLINK_ON : S_BLINK_OFF;
            default:     state_nxt = S_BLINK_ON;
          endcase
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Timers restart on every state entry and on every flash (re)trigger.
  assign clr = i_flash || (state_nxt != state);

  // Logical lit level for the state being entered this clock.
  always_comb begin
    lit_nxt = 1'b0;
    case (state_nxt)
      S_ON, S_BLINK_ON: lit_nxt = pwm_on;
      S_FLASH:          lit_nxt = 1'b1;
      default:          lit_nxt = 1'b0;
    endcase
  end

  // FSM state, phase tick counter, PWM ramp and registered pin outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_OFF;
      tick_cnt  <= '0;
      pwm_cnt   <= '0;
      o_busy    <= 1'b0;
      o_drv_led <= ~p_mode;
    end else begin
      state <= state_nxt;
      if (clr) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      pwm_cnt   <= pwm_cnt + p_pwm_bits'(1);
      o_busy    <= (state_nxt == S_FLASH);
      o_drv_led <= p_mode ? lit_nxt : ~lit_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_drv_led.sv
// Bench for drv_led: two instances (active-low and active-high) share all
// inputs; a clock-counting reference model predicts pin, busy and state.
module tb_drv_led;
  import drv_led_pkg::*;

  localparam int SCALE      = 2;
  localparam int PWMB       = 2;
  localparam int BLINK      = 3;
  localparam int FLASH      = 2;
  localparam int BLINK_CLKS = BLINK * (1 << SCALE);
  localparam int FLASH_CLKS = FLASH * (1 << SCALE);
  localparam int PERIOD     = 1 << PWMB;

  logic            clk;
  logic            rst;
  logic [1:0]      mode;
  logic [PWMB-1:0] level;
  logic            flash;
  logic            busy0, led0, busy1, led1;
  state_t          st0, st1;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in clocks rather than ticks.
  state_t m_state;
  int     m_elapsed;
  int     m_remain;
  int     m_k;
  logic   m_lit;

  drv_led #(.p_scale(SCALE), .p_mode(ACTIVE_LOW), .p_pwm_bits(PWMB),
            .p_blink_len(BLINK), .p_flash_len(FLASH)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_level(level),
    .i_flash(flash), .o_busy(busy0), .o_drv_led(led0), .o_state(st0));

  drv_led #(.p_scale(SCALE), .p_mode(ACTIVE_HIGH), .p_pwm_bits(PWMB),
            .p_blink_len(BLINK), .p_flash_len(FLASH)) dut_h (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_level(level),
    .i_flash(flash), .o_busy(busy1), .o_drv_led(led1), .o_state(st1));

  // Clock and global watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: apply the rules for one rising edge.
  task automatic model_step();
    logic pwm;
    if (rst) begin
      m_state = S_OFF; m_k = 0; m_lit = 1'b0; m_elapsed = 0; m_remain = 0;
    end else begin
      pwm = (level == PWMB'(PERIOD - 1)) || ((m_k % PERIOD) < int'(level));
      m_k++;
      if (flash) begin
        m_state = S_FLASH; m_remain = FLASH_CLKS;
      end else if (m_state == S_FLASH) begin
        m_remain--;
        if (m_remain == 0) begin
          m_elapsed = 0;
          m_state = (mode == LED_ON) ? S_ON : (mode == LED_BLINK) ? S_BLINK_ON : S_OFF;
        end
      end else if (mode == LED_ON) begin
        m_state = S_ON;
      end else if (mode == LED_BLINK) begin
        if (m_state == S_BLINK_ON || m_state == S_BLINK_OFF) begin
          m_elapsed++;
          if (m_elapsed == BLINK_CLKS) begin
            m_elapsed = 0;
            m_state = (m_state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
          end
        end else begin
          m_state = S_BLINK_ON; m_elapsed = 0;
        end
      end else begin
        m_state = S_OFF;
      end
      m_lit = (m_state == S_FLASH) ? 1'b1 :
              (m_state == S_ON || m_state == S_BLINK_ON) ? pwm : 1'b0;
    end
  endtask

  // Driver: advance one clock, update the model, sample 1 time unit later.
  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = LED_OFF; level = '0; flash = 1'b0;
    repeat (3) begin
      clk_step();
      checks++;
      if (led0 !== 1'b1 || led1 !== 1'b0 || busy0 !== 1'b0 || st0 !== S_OFF) begin
        errors++;
        $display("FAIL reset_hold: got led0=%b led1=%b busy=%b state=%0d required 1 0 0 %0d",
                 led0, led1, busy0, st0, S_OFF);
      end
    end
    rst = 1'b0;
    repeat (4) begin
      clk_step();
      checks++;
      if (led0 !== 1'b1 || busy0 !== 1'b0 || st0 !== S_OFF) begin
        errors++;
        $display("FAIL reset_release: got led0=%b busy=%b state=%0d required 1 0 %0d",
                 led0, busy0, st0, S_OFF);
      end
    end
  endtask

  task automatic test_on();
    int lows;
    mode = LED_ON; level = 2'd3;
    repeat (8) begin
      clk_step();
      checks++;
      if (led0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL on_full: got led0=%b busy=%b required 0 0", led0, busy0);
      end
    end
    level = 2'd1; lows = 0;
    repeat (16) begin
      clk_step();
      if (led0 === 1'b0) lows++;
      checks++;
      if (led0 !== ~m_lit) begin
        errors++;
        $display("FAIL on_dim_pin: got %b required %b", led0, ~m_lit);
      end
    end
    checks++;
    if (lows != 4) begin
      errors++;
      $display("FAIL on_dim_duty: got %0d low clocks in 16 required 4", lows);
    end
    level = 2'd0;
    repeat (8) begin
      clk_step();
      checks++;
      if (led0 !== 1'b1) begin
        errors++;
        $display("FAIL on_dark: got %b required 1", led0);
      end
    end
  endtask

  task automatic test_blink();
    logic exp;
    mode = LED_BLINK; level = 2'd3;
    for (int i = 0; i < 3 * BLINK_CLKS; i++) begin
      clk_step();
      exp = ((i / BLINK_CLKS) % 2 == 1) ? 1'b1 : 1'b0;
      checks++;
      if (led0 !== exp || led1 !== ~exp) begin
        errors++;
        $display("FAIL blink_phase clk %0d: got led0=%b led1=%b required %b %b",
                 i, led0, led1, exp, ~exp);
      end
    end
  endtask

  task automatic test_flash();
    int guard;
    mode = LED_BLINK; level = 2'd3; guard = 0;
    while (m_state != S_BLINK_OFF && guard < 40) begin
      clk_step();
      guard++;
    end
    checks++;
    if (st0 !== S_BLINK_OFF) begin
      errors++;
      $display("FAIL flash_setup: got state %0d required %0d", st0, S_BLINK_OFF);
    end
    level = 2'd0;
    clk_step();
    flash = 1'b1;
    clk_step();
    flash = 1'b0;
    for (int i = 0; i < FLASH_CLKS; i++) begin
      if (i > 0) clk_step();
      checks++;
      if (led0 !== 1'b0 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL flash_active clk %0d: got led0=%b busy=%b required 0 1", i, led0, busy0);
      end
    end
    clk_step();
    checks++;
    if (busy0 !== 1'b0 || st0 !== S_BLINK_ON || led0 !== 1'b1) begin
      errors++;
      $display("FAIL flash_end: got busy=%b state=%0d led0=%b required 0 %0d 1",
               busy0, st0, led0, S_BLINK_ON);
    end
  endtask

  task automatic test_back_to_back();
    int busy_len;
    mode = LED_BLINK; level = 2'd3;
    flash = 1'b1;
    clk_step();
    flash = 1'b0;
    busy_len = (busy0 === 1'b1) ? 1 : 0;
    repeat (4) begin
      clk_step();
      if (busy0 === 1'b1) busy_len++;
    end
    mode = LED_OFF; flash = 1'b1;
    clk_step();
    flash = 1'b0;
    if (busy0 === 1'b1) busy_len++;
    for (int i = 0; i < 30; i++) begin
      clk_step();
      if (busy0 !== 1'b1) break;
      busy_len++;
      checks++;
      if (led0 !== 1'b0) begin
        errors++;
        $display("FAIL retrig_lit: got led0=%b required 0 while busy", led0);
      end
    end
    checks++;
    if (busy_len != 13) begin
      errors++;
      $display("FAIL retrig_len: got %0d busy clocks required 13", busy_len);
    end
    checks++;
    if (led0 !== 1'b1 || st0 !== S_OFF) begin
      errors++;
      $display("FAIL retrig_after: got led0=%b state=%0d required 1 %0d", led0, st0, S_OFF);
    end
  endtask

  task automatic test_reset_mid_blink();
    mode = LED_BLINK; level = 2'd3;
    repeat (16) clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    checks++;
    if (led1 !== 1'b0 || st1 !== S_OFF || busy1 !== 1'b0 || led0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_blink: got led1=%b state=%0d busy=%b led0=%b required 0 %0d 0 1",
               led1, st1, busy1, led0, S_OFF);
    end
    for (int i = 0; i < BLINK_CLKS + 2; i++) begin
      clk_step();
      checks++;
      if (led1 !== ((i < BLINK_CLKS) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL rst_restart clk %0d: got led1=%b required %b",
                 i, led1, (i < BLINK_CLKS) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  level = PWMB'($urandom_range(0, PERIOD - 1));
      flash = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      clk_step();
      checks++;
      if (led0 !== ~m_lit || led1 !== m_lit || busy0 !== (m_state == S_FLASH) ||
          busy1 !== busy0 || st0 !== m_state) begin
        errors++;
        $display("FAIL random clk %0d: got led0=%b led1=%b busy=%b state=%0d required %b %b %b %0d",
                 i, led0, led1, busy0, st0, ~m_lit, m_lit, (m_state == S_FLASH), m_state);
      end
    end
    rst = 1'b0; flash = 1'b0;
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1; mode = LED_OFF; level = '0; flash = 1'b0;
    m_state = S_OFF; m_elapsed = 0; m_remain = 0; m_k = 0; m_lit = 1'b0;
    test_reset();
    test_on();
    test_blink();
    test_flash();
    test_back_to_back();
    test_reset_mid_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drv_led.md
# drv_led

Output-side pin driver for a discrete LED: the transmit-direction counterpart of the switch/button input driver. It turns a logical command (off / on / blink, plus a one-shot flash request typically fed from a switch driver's click pulse) into a polarity-correct, PWM-dimmed pin level. It sits between control logic and the board pin, one instance per LED.

## Interface
- p_scale, 5: prescaler width; one tick every 2^p_scale clocks.
- p_mode, 0: pin polarity; 0 = active-low (pin low lights LED, pull-up wiring), 1 = active-high.
- p_pwm_bits, 4: brightness resolution.
- p_blink_len, 8: blink half-period in ticks (≥1).
- p_flash_len, 4: flash duration in ticks (≥1).
- i_clk  in  1  clock; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_mode  in  2  00 off, 01 on, 10 blink, 11 reserved (treated as off).
- i_level  in  p_pwm_bits  brightness; 0 = dark, all-ones = fully on.
- i_flash  in  1  single-cycle flash request.
- o_busy  out  1  high while a flash is in progress.
- o_drv_led  out  1  physical pin level.

## Operation
- Internal logical signal lit drives the pin: o_drv_led = p_mode ? lit : ~lit.
- PWM: free-running p_pwm_bits counter, +1 every clock, wraps. pwm_on = (i_level == all-ones) | (pwm_cnt < i_level).
- FSM states: S_OFF, S_ON, S_BLINK_ON, S_BLINK_OFF, S_FLASH.
- lit per state: S_OFF 0; S_ON pwm_on; S_BLINK_ON pwm_on; S_BLINK_OFF 0; S_FLASH 1 (full brightness, ignores i_level).
- Mode dispatch, applied in every non-flash state each clock: 00/11 -> S_OFF; 01 -> S_ON; 10 -> S_BLINK_ON if not already blinking, otherwise stay in the blink phase.
- Blink: tick counter counts ticks in the current phase. On the p_blink_len-th tick, S_BLINK_ON <-> S_BLINK_OFF and the counter clears.
- Flash: i_flash high in any state -> S_FLASH, with prescaler and tick counter cleared. After p_flash_len ticks the FSM returns to the state dictated by current i_mode; blink restarts at S_BLINK_ON.
- i_flash during S_FLASH retriggers: counters reload and the full p_flash_len restarts.
- i_mode changes during S_FLASH are ignored until the flash ends.
- Priority per clock: i_rst > i_flash > i_mode.
- Prescaler and tick counter clear on every state entry, so phases are exact: blink half-period = p_blink_len·2^p_scale clocks, flash = p_flash_len·2^p_scale clocks.
- o_busy = (state == S_FLASH).

## Timing
- Reset: state S_OFF, all counters 0, o_busy 0, o_drv_led = inactive level (1 when p_mode=0, 0 when p_mode=1). Reset mid-flash or mid-blink aborts immediately.
- o_drv_led and o_busy are registered. An input sampled at rising edge N is reflected after edge N (1-cycle latency).
- Tick is asserted on the clock where prescaler == all-ones; the prescaler then wraps to 0.
- PWM period = 2^p_pwm_bits clocks. Duty = i_level/2^p_pwm_bits, except all-ones gives 100 %.
- i_level is sampled every clock, with no hold requirement. A change takes effect on the next PWM comparison.
- i_flash is edge-agnostic: held high, it retriggers every clock, so the flash lasts until release + p_flash_len ticks.

## Structure
- Package drv_led_pkg holds:
  - the state enum (S_OFF…S_FLASH);
  - mode constants LED_OFF, LED_ON, LED_BLINK;
  - polarity constants ACTIVE_LOW=0, ACTIVE_HIGH=1. These replace text macros and are shared with drv_switch polarity.
- One sub-module, drv_led_tick: p_scale prescaler with synchronous clear input and tick output. It is reusable by other drivers.
- FSM, tick counter, PWM counter and output register live in drv_led.

## Test plan
Bench parameters: p_scale=2, p_blink_len=3, p_flash_len=2, p_pwm_bits=2, p_mode=0 unless stated.
1. Reset held 3 clocks, then released with i_mode=00 -> o_drv_led=1 and o_busy=0 throughout.
2. i_mode=01, i_level=3 -> o_drv_led=0 continuously from 1 clock after the mode change. With i_level=1 -> low 1 of every 4 clocks. With i_level=0 -> constantly 1.
3. i_mode=10, i_level=3 -> o_drv_led alternates 12 clocks low / 12 clocks high, first low phase starting 1 clock after the mode change.
4. i_flash pulse during the blink-off phase, i_level=0 -> o_drv_led=0 and o_busy=1 for exactly 8 clocks, then blink resumes in the on phase.
5. Second i_flash pulse 5 clocks into a flash -> flash extends to 13 clocks total. i_mode=00 applied during the flash -> LED off only after o_busy falls.
6. p_mode=1 with a mid-blink i_rst pulse -> o_drv_led=0 on the clock after reset, state S_OFF, counters cleared.
